// File: rtl/phase_step_mon_pkg.sv
// Shared types and helpers for the phase-step settling monitor.
// Optional feature macro: PHASE_STEP_MON_PEAK_EN (per-channel peak |pe| tracking).
package phase_step_mon_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrack = 2'd1,
    StDone  = 2'd2
  } ch_state_e;

  // Channels slice this down to their own CNT_WIDTH to get the saturation limit.
  localparam int unsigned CntWidthMax = 32;
  localparam logic [CntWidthMax-1:0] CntAllOnes = '1;

  // x is the sample sign-extended to 32 bits; the result is clamped to 2^(width-1)-1
  // so the most negative sample does not wrap.
  function automatic logic [31:0] sat_abs(input logic [31:0] x, input int unsigned width);
    logic [31:0] lim;
    logic [31:0] mag;
    lim = (32'd1 << (width - 1)) - 32'd1;
    mag = x[31] ? (~x + 32'd1) : x;
    if (mag > lim) begin
      mag = lim;
    end
    return mag;
  endfunction

endpackage

// File: rtl/phase_step_mon_ch.sv
// One settling-monitor channel: FSM, sample/in-band counters and sticky results.
// PHASE_STEP_MON_PEAK_EN builds the peak register; otherwise peak is tied to 0.
module phase_step_mon_ch
  import phase_step_mon_pkg::*;
#(
  parameter int unsigned PE_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned HOLD_WIDTH = 8
) (
  input  logic                  clk_ref,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  pe_valid,
  input  logic [PE_WIDTH-1:0]   pe,
  input  logic [PE_WIDTH-2:0]   tol,
  input  logic [HOLD_WIDTH-1:0] hold,
  output logic                  busy,
  output logic                  done,
  output logic                  settled,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  settle_time,
  output logic [PE_WIDTH-2:0]   peak
);

  localparam logic [CNT_WIDTH-1:0]  CntLimit = CntAllOnes[CNT_WIDTH-1:0];
  localparam logic [HOLD_WIDTH-1:0] InMax    = '1;

  ch_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
  logic [HOLD_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic                  settled_q, settled_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  settle_time_q, settle_time_d;

  logic [PE_WIDTH-2:0]   abs_pe;
  logic [HOLD_WIDTH-1:0] hold_eff;
  logic [CNT_WIDTH-1:0]  sample_base, sample_inc;
  logic [HOLD_WIDTH-1:0] in_base, in_inc;
  logic                  take, in_band, settle_hit, sat_hit, exit_hit;

  assign abs_pe   = (PE_WIDTH-1)'(sat_abs(32'(signed'(pe)), PE_WIDTH));
  assign in_band  = (abs_pe <= tol);
  assign hold_eff = (hold == '0) ? HOLD_WIDTH'(1) : hold;

  // A start restarts from cleared counters, and a sample in the same cycle is sample 1.
  always_comb begin
    sample_base = start ? '0 : sample_cnt_q;
    in_base     = start ? '0 : in_cnt_q;
    take        = pe_valid && (start || (state_q == StTrack));
    sample_inc  = sample_base + CNT_WIDTH'(1);
    if (!in_band) begin
      in_inc = '0;
    end else if (in_base == InMax) begin
      in_inc = in_base;
    end else begin
      in_inc = in_base + HOLD_WIDTH'(1);
    end
    settle_hit   = take && (in_inc >= hold_eff);
    sat_hit      = take && (sample_inc == CntLimit);
    exit_hit     = settle_hit || sat_hit;
    sample_cnt_d = take ? sample_inc : sample_base;
    in_cnt_d     = take ? in_inc : in_base;

    settled_d     = start ? 1'b0 : settled_q;
    timeout_d     = start ? 1'b0 : timeout_q;
    settle_time_d = start ? '0 : settle_time_q;
    if (settle_hit) begin
      settled_d     = 1'b1;
      timeout_d     = 1'b0;
      // Exact modulo 2^CNT_WIDTH since the true result never exceeds sample_inc.
      settle_time_d = sample_inc - CNT_WIDTH'(hold_eff) + CNT_WIDTH'(1);
    end else if (sat_hit) begin
      settled_d     = 1'b0;
      timeout_d     = 1'b1;
      settle_time_d = '1;
    end
  end

  always_ff @(posedge clk_ref or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (exit_hit) begin
      state_d = StDone;
    end else if (start || (state_q == StTrack)) begin
      state_d = StTrack;
    end
  end

  always_comb begin
    busy        = (state_q == StTrack);
    done        = (state_q == StDone);
    settled     = settled_q;
    timeout     = timeout_q;
    settle_time = settle_time_q;
  end

  always_ff @(posedge clk_ref or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt_q  <= '0;
      in_cnt_q      <= '0;
      settled_q     <= 1'b0;
      timeout_q     <= 1'b0;
      settle_time_q <= '0;
    end else begin
      sample_cnt_q  <= sample_cnt_d;
      in_cnt_q      <= in_cnt_d;
      settled_q     <= settled_d;
      timeout_q     <= timeout_d;
      settle_time_q <= settle_time_d;
    end
  end

`ifdef PHASE_STEP_MON_PEAK_EN
  logic [PE_WIDTH-2:0] peak_q, peak_d;

  always_comb begin
    peak_d = start ? '0 : peak_q;
    if (take && (abs_pe > peak_d)) begin
      peak_d = abs_pe;
    end
  end

  always_ff @(posedge clk_ref or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: rtl/phase_step_monitor.sv
// Multi-channel phase-step settling monitor; one phase_step_mon_ch per channel.
// Define PHASE_STEP_MON_PEAK_EN to build the per-channel peak |pe| registers.
module phase_step_monitor
  import phase_step_mon_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PE_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned HOLD_WIDTH = 8
) (
  input  logic                          clk_ref,
  input  logic                          reset_n,
  input  logic [N_CH-1:0]               start,
  input  logic [N_CH-1:0]               pe_valid,
  input  logic [N_CH*PE_WIDTH-1:0]      pe,
  input  logic [PE_WIDTH-2:0]           tol,
  input  logic [HOLD_WIDTH-1:0]         hold,
  output logic [N_CH-1:0]               busy,
  output logic [N_CH-1:0]               done,
  output logic [N_CH-1:0]               settled,
  output logic [N_CH-1:0]               timeout,
  output logic [N_CH*CNT_WIDTH-1:0]     settle_time,
  output logic [N_CH*(PE_WIDTH-1)-1:0]  peak
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    phase_step_mon_ch #(
      .PE_WIDTH  (PE_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .HOLD_WIDTH(HOLD_WIDTH)
    ) u_ch (
      .clk_ref    (clk_ref),
      .reset_n    (reset_n),
      .start      (start[c]),
      .pe_valid   (pe_valid[c]),
      .pe         (pe[c*PE_WIDTH +: PE_WIDTH]),
      .tol        (tol),
      .hold       (hold),
      .busy       (busy[c]),
      .done       (done[c]),
      .settled    (settled[c]),
      .timeout    (timeout[c]),
      .settle_time(settle_time[c*CNT_WIDTH +: CNT_WIDTH]),
      .peak       (peak[c*(PE_WIDTH-1) +: (PE_WIDTH-1)])
    );
  end

endmodule
